// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC rotation datapath.
// Covers the state encoding, default sizes, the gain constant and the elaboration-time arctangent table.
package cordic_pkg;

  typedef enum logic [1:0] {IDLE, ITERATE, DONE} state_t;

  localparam int WIDTH_DEF   = 16;
  localparam int ANGLE_W_DEF = 16;
  localparam int ITER_DEF    = 16;
  localparam int K_GAIN      = 19898;  // 0.60725 * 2^15

  // round(atan(2^-i) * 2^angle_w / 2pi); Taylor series evaluated only at elaboration
  function automatic int atan_entry(input int i, input int angle_w = ANGLE_W_DEF);
    real x;
    real x2;
    real term;
    real sum;
    if (i == 0) begin
      return 1 << (angle_w - 3);
    end
    x    = 1.0 / (2.0 ** i);
    x2   = x * x;
    term = x;
    sum  = 0.0;
    for (int n = 0; n < 40; n++) begin
      sum  = sum + (((n % 2) == 1) ? -term : term) / (2 * n + 1);
      term = term * x2;
    end
    return $rtoi(sum * (2.0 ** angle_w) / (2.0 * 3.14159265358979) + 0.5);
  endfunction

endpackage

// File: rtl/cordic_rotation_datapath_if.sv
// Operand/result bundle between the input mux controller and the CORDIC datapath.
interface cordic_rotation_datapath_if #(
  parameter int WIDTH   = 16,
  parameter int ANGLE_W = 16
);
  logic                      load;
  logic signed [WIDTH-1:0]   x_in;
  logic signed [WIDTH-1:0]   y_in;
  logic signed [ANGLE_W-1:0] z_in;
  logic signed [WIDTH-1:0]   x_out;
  logic signed [WIDTH-1:0]   y_out;
  logic signed [ANGLE_W-1:0] z_out;
  logic                      busy;
  logic                      out_valid;

  modport master (
    output load, x_in, y_in, z_in,
    input  x_out, y_out, z_out, busy, out_valid
  );

  modport slave (
    input  load, x_in, y_in, z_in,
    output x_out, y_out, z_out, busy, out_valid
  );
endinterface

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent ROM, one entry per micro-rotation; indices past ITER read as zero.
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int ANGLE_W = 16,
  parameter int ITER    = 16,
  parameter int IDX_W   = 6
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [ANGLE_W-1:0] atan
);

  logic [ANGLE_W-1:0] rom [ITER];

  generate
    for (genvar gi = 0; gi < ITER; gi++) begin : g_rom
      localparam int VAL = atan_entry(gi, ANGLE_W);
      assign rom[gi] = ANGLE_W'(VAL);
    end
  endgenerate

  always_comb begin
    atan = '0;
    for (int k = 0; k < ITER; k++) begin
      if (idx == IDX_W'(k)) begin
        atan = rom[k];
      end
    end
  end

endmodule

// File: rtl/cordic_rotation_datapath.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, results with a one-cycle out_valid.
// Optional CORDIC_GAIN_COMP_EN adds a 1/K gain-compensation cycle after the last rotation.
module cordic_rotation_datapath
  import cordic_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ANGLE_W = ANGLE_W_DEF,
  parameter int ITER    = ITER_DEF
) (
  input logic                       clk,
  input logic                       rst,
  cordic_rotation_datapath_if.slave bus
);

  localparam int IDX_W = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITER - 1);

  state_t                    state_q, state_d;
  logic signed [WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic signed [ANGLE_W-1:0] z_q, z_d;
  logic [IDX_W-1:0]          i_q, i_d;
  logic signed [WIDTH-1:0]   x_out_q, x_out_d, y_out_q, y_out_d;
  logic signed [ANGLE_W-1:0] z_out_q, z_out_d;
  logic                      out_valid_q, out_valid_d;

  logic [ANGLE_W-1:0]        atan;
  logic signed [WIDTH-1:0]   x_sh, y_sh, x_rot, y_rot;
  logic signed [ANGLE_W-1:0] z_rot;

  cordic_atan_lut #(
    .ANGLE_W (ANGLE_W),
    .ITER    (ITER),
    .IDX_W   (IDX_W)
  ) u_atan_lut (
    .idx  (i_q),
    .atan (atan)
  );

  // z >= 0 rotates counter-clockwise; sums wrap at their natural width
  always_comb begin
    x_sh = x_q >>> i_q;
    y_sh = y_q >>> i_q;
    if (!z_q[ANGLE_W-1]) begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan;
    end else begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [16:0]       K_S = 17'(K_GAIN);
  localparam logic signed [WIDTH+16:0] RND = (WIDTH + 17)'(1 << 14);
  logic signed [WIDTH+16:0] x_prod, y_prod;

  always_comb begin
    x_prod = x_q * K_S + RND;
    y_prod = y_q * K_S + RND;
  end
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    i_d         = i_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    z_out_d     = z_out_q;
    out_valid_d = 1'b0;
    if (bus.load) begin
      x_d     = bus.x_in;
      y_d     = bus.y_in;
      z_d     = bus.z_in;
      i_d     = '0;
      state_d = ITERATE;
    end else if (state_q == ITERATE) begin
`ifdef CORDIC_GAIN_COMP_EN
      // i == ITER marks the extra compensation cycle after the final rotation
      if (i_q == IDX_W'(ITER)) begin
        x_out_d     = x_prod[WIDTH+14:15];
        y_out_d     = y_prod[WIDTH+14:15];
        z_out_d     = z_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end else begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        i_d = i_q + IDX_W'(1);
      end
`else
      x_d = x_rot;
      y_d = y_rot;
      z_d = z_rot;
      i_d = i_q + IDX_W'(1);
      if (i_q == LAST_IDX) begin
        x_out_d     = x_rot;
        y_out_d     = y_rot;
        z_out_d     = z_rot;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      i_q         <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      z_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      i_q         <= i_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      z_out_q     <= z_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.x_out     = x_out_q;
  assign bus.y_out     = y_out_q;
  assign bus.z_out     = z_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == ITERATE);

endmodule

// File: tb/tb_cordic_rotation_datapath.sv
// Self-checking bench: directed angle cases, abort/reset cases and random operands
// compared against an integer CORDIC reference built from real-valued arctangents.
module tb_cordic_rotation_datapath;

  localparam int ITER = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITER + 1;
`else
  localparam int LAT = ITER;
`endif

  logic clk;
  logic rst;
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  int   lut [32];
  int   last_x, last_y, last_z;

  cordic_rotation_datapath_if #(.WIDTH(16), .ANGLE_W(16)) bus_if ();

  cordic_rotation_datapath #(.WIDTH(16), .ANGLE_W(16), .ITER(ITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp, input int tol = 0);
    int diff;
    cmp_cnt++;
    diff = (got > exp) ? got - exp : exp - got;
    if (diff > tol) begin
      err_cnt++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  task automatic ref_model(input int xi, input int yi, input int zi,
                           output int xo, output int yo, output int zo);
    int x, y, z, nx, ny, nz;
    x = xi; y = yi; z = zi;
    for (int i = 0; i < ITER; i++) begin
      if (z >= 0) begin
        nx = x - (y >>> i); ny = y + (x >>> i); nz = z - lut[i];
      end else begin
        nx = x + (y >>> i); ny = y - (x >>> i); nz = z + lut[i];
      end
      x = wrap16(nx); y = wrap16(ny); z = wrap16(nz);
    end
`ifdef CORDIC_GAIN_COMP_EN
    x = wrap16((x * 19898 + 16384) >>> 15);
    y = wrap16((y * 19898 + 16384) >>> 15);
`endif
    xo = x; yo = y; zo = z;
  endtask

  task automatic drive(input int xi, input int yi, input int zi);
    bus_if.x_in = 16'(xi);
    bus_if.y_in = 16'(yi);
    bus_if.z_in = 16'(zi);
  endtask

  task automatic run_op(input string tag, input int xi, input int yi, input int zi);
    int k, bcnt, ex, ey, ez;
    bit seen;
    ref_model(xi, yi, zi, ex, ey, ez);
    @(negedge clk);
    drive(xi, yi, zi);
    bus_if.load = 1'b1;
    @(negedge clk);
    bus_if.load = 1'b0;
    k = 0; seen = 1'b0; bcnt = 0;
    if (bus_if.busy) bcnt++;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (bus_if.busy) bcnt++;
      if (bus_if.out_valid) seen = 1'b1;
    end
    check_val({tag, ".latency"}, seen ? k : -1, LAT);
    check_val({tag, ".busy_cycles"}, bcnt, LAT);
    last_x = int'(bus_if.x_out);
    last_y = int'(bus_if.y_out);
    last_z = int'(bus_if.z_out);
    check_val({tag, ".x_out"}, last_x, ex);
    check_val({tag, ".y_out"}, last_y, ey);
    check_val({tag, ".z_out"}, last_z, ez);
    @(negedge clk);
    check_val({tag, ".valid_drop"}, int'(bus_if.out_valid), 0);
    check_val({tag, ".x_hold"}, int'(bus_if.x_out), ex);
    $display("op %s: x=%0d y=%0d z=%0d -> x_out=%0d y_out=%0d z_out=%0d lat=%0d", tag, xi, yi, zi,
             last_x, last_y, last_z, k);
  endtask

  initial begin
    int k, pulses, pos, busyc, ex, ey, ez;
    for (int i = 0; i < 32; i++) begin
      lut[i] = $rtoi($atan(1.0 / (2.0 ** i)) * 65536.0 / (2.0 * 3.141592653589793) + 0.5);
    end
    rst = 1'b0;
    bus_if.load = 1'b0;
    drive(0, 0, 0);
    #2;
    check_val("reset.x_out", int'(bus_if.x_out), 0);
    check_val("reset.busy", int'(bus_if.busy), 0);
    check_val("reset.out_valid", int'(bus_if.out_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

`ifdef CORDIC_GAIN_COMP_EN
    run_op("gain45", 16384, 0, 8192);
    check_val("gain45.x_abs", last_x, 11585, 6);
    check_val("gain45.y_abs", last_y, 11585, 6);
`else
    run_op("zero", 9949, 0, 0);
    check_val("zero.x_abs", last_x, 16384, 4);
    check_val("zero.y_abs", last_y, 0, 4);
    check_val("zero.z_res", last_z, 0, 2);
    run_op("pos45", 9949, 0, 8192);
    check_val("pos45.x_abs", last_x, 11585, 4);
    check_val("pos45.y_abs", last_y, 11585, 4);
    run_op("neg45", 9949, 0, -8192);
    check_val("neg45.y_abs", last_y, -11585, 4);
    run_op("pos90", 9949, 0, 16384);
    check_val("pos90.x_abs", last_x, 0, 4);
    check_val("pos90.y_abs", last_y, 16384, 4);
`endif

    // abort: second load with z=0 six cycles after the first
    ref_model(9949, 0, 0, ex, ey, ez);
    @(negedge clk);
    drive(9949, 0, 8192);
    bus_if.load = 1'b1;
    @(negedge clk);
    bus_if.load = 1'b0;
    k = 0; pulses = 0; pos = -1;
    for (int s = 0; s < 30; s++) begin
      if (k == 5) begin
        drive(9949, 0, 0);
        bus_if.load = 1'b1;
      end
      @(negedge clk);
      k++;
      bus_if.load = 1'b0;
      if (bus_if.out_valid) begin
        pulses++;
        pos = k;
      end
    end
    check_val("abort.pulses", pulses, 1);
    check_val("abort.pulse_pos", pos, 6 + LAT);
    check_val("abort.x_hold", int'(bus_if.x_out), ex);
    check_val("abort.y_hold", int'(bus_if.y_out), ey);
    $display("op abort: pulses=%0d at=%0d x_out=%0d y_out=%0d", pulses, pos,
             int'(bus_if.x_out), int'(bus_if.y_out));

    // asynchronous reset five cycles into an operation
    @(negedge clk);
    drive(9949, 0, 8192);
    bus_if.load = 1'b1;
    @(negedge clk);
    bus_if.load = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("rst_mid.x_out", int'(bus_if.x_out), 0);
    check_val("rst_mid.y_out", int'(bus_if.y_out), 0);
    check_val("rst_mid.z_out", int'(bus_if.z_out), 0);
    check_val("rst_mid.busy", int'(bus_if.busy), 0);
    check_val("rst_mid.out_valid", int'(bus_if.out_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0; busyc = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus_if.out_valid) pulses++;
      if (bus_if.busy) busyc++;
    end
    check_val("rst_mid.no_pulse", pulses, 0);
    check_val("rst_mid.idle", busyc, 0);
    $display("op reset_mid: pulses=%0d busy_cycles=%0d", pulses, busyc);

    for (int n = 0; n < 20; n++) begin
      int rx, ry, rz;
      rx = int'($urandom_range(18000)) - 9000;
      ry = int'($urandom_range(18000)) - 9000;
      rz = int'($urandom_range(32768)) - 16384;
      run_op($sformatf("rand%0d", n), rx, ry, rz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
